lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_pkg.sv | 30 +++
 rtl/lsu_ctrl_ext.sv | 29 ++
 rtl/lsu_ctrl.sv | 135 +++++++++++++
 tb/tb_lsu_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared data-memory definitions for the load/store unit: widths, access-size codes and FSM states.
// The size helper returns the number of bytes one access touches.
package lsu_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int DMEM_WIDTH = 8;
    localparam int DMEM_NUM   = 256;
    localparam int SL_WIDTH   = 2;

    localparam logic [SL_WIDTH-1:0] SL_NONE = 2'd0;
    localparam logic [SL_WIDTH-1:0] SL_B    = 2'd1;
    localparam logic [SL_WIDTH-1:0] SL_H    = 2'd2;
    localparam logic [SL_WIDTH-1:0] SL_W    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic [31:0] slBytes(input logic [SL_WIDTH-1:0] size);
        case (size)
            SL_B:    slBytes = 32'd1;
            SL_H:    slBytes = 32'd2;
            SL_W:    slBytes = 32'd4;
            default: slBytes = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_ext.sv
// Load-data extension: widens the raw zero-extended memory word to XLEN according to
// access size, sign-extending from bit 7 or bit 15 unless the load is unsigned.
module lsu_ext #(
    parameter int XLEN = 32
) (
    input  logic [lsu_ctrl_pkg::SL_WIDTH-1:0] i_size,
    input  logic                              i_unsigned,
    input  logic [XLEN-1:0]                   i_raw,
    output logic [XLEN-1:0]                   o_ext
);
    import lsu_ctrl_pkg::*;

    logic w_fillB;
    logic w_fillH;

    assign w_fillB = ~i_unsigned & i_raw[7];
    assign w_fillH = ~i_unsigned & i_raw[15];

    always_comb begin
        o_ext = '0;
        case (i_size)
            SL_B:    o_ext = {{(XLEN-8){w_fillB}}, i_raw[7:0]};
            SL_H:    o_ext = {{(XLEN-16){w_fillH}}, i_raw[15:0]};
            SL_W:    o_ext = i_raw;
            default: o_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, performs a single-cycle
// data-memory access and holds the response until the consumer takes it.
module lsu_ctrl #(
    parameter int XLEN  = lsu_ctrl_pkg::XLEN,
    parameter int AW    = lsu_ctrl_pkg::DMEM_WIDTH,
    parameter int DEPTH = lsu_ctrl_pkg::DMEM_NUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [lsu_ctrl_pkg::SL_WIDTH-1:0] req_size,
    input  logic                              req_unsigned,
    input  logic [AW-1:0]                     req_addr,
    input  logic [XLEN-1:0]                   req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [XLEN-1:0]                   rsp_rdata,
    output logic                              rsp_err,
    output logic                              dm_memWrite,
    output logic [lsu_ctrl_pkg::SL_WIDTH-1:0] dm_lwhb,
    output logic [lsu_ctrl_pkg::SL_WIDTH-1:0] dm_swhb,
    output logic [AW-1:0]                     dm_addr,
    output logic [XLEN-1:0]                   dm_wd,
    input  logic [XLEN-1:0]                   dm_dt
);
    import lsu_ctrl_pkg::*;

    lsu_state_e              r_state;
    lsu_state_e              w_nextState;
    logic                    r_we;
    logic [SL_WIDTH-1:0]     r_size;
    logic                    r_unsigned;
    logic [AW-1:0]           r_addr;
    logic [XLEN-1:0]         r_wdata;
    logic [XLEN-1:0]         r_rdata;
    logic                    r_err;

    logic [31:0]             w_lastByte;
    logic                    w_misaligned;
    logic                    w_illegal;
    logic [XLEN-1:0]         w_extData;

    // Legality is judged on the incoming request so an illegal one can skip ACCESS.
    assign w_lastByte   = 32'(req_addr) + slBytes(req_size) - 32'd1;
    assign w_misaligned = ((req_size == SL_H) && req_addr[0]) ||
                          ((req_size == SL_W) && (req_addr[1:0] != 2'b00));
    assign w_illegal    = (req_size == SL_NONE) || w_misaligned ||
                          (w_lastByte >= 32'(DEPTH));

    lsu_ext #(.XLEN(XLEN)) u_ext (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_raw      (dm_dt),
        .o_ext      (w_extData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        dm_memWrite = 1'b0;
        dm_lwhb     = SL_NONE;
        dm_swhb     = SL_NONE;
        dm_addr     = '0;
        dm_wd       = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_nextState = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                dm_addr     = r_addr;
                dm_wd       = r_wdata;
                dm_memWrite = r_we;
                dm_swhb     = r_we ? r_size : SL_NONE;
                dm_lwhb     = r_we ? SL_NONE : r_size;
                w_nextState = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Response data is only written on accept and at the end of ACCESS, so it holds through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= SL_NONE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_illegal;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= r_we ? '0 : w_extData;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a little-endian byte-array data memory model.
// Inputs change and outputs are sampled away from the rising clock edge.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_memWrite;
    logic [1:0]  dm_lwhb;
    logic [1:0]  dm_swhb;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_dt;

    logic [7:0]  mem [0:255];
    int          writeCount = 0;
    int          passCount = 0;
    int          totalChecks = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .AW(8), .DEPTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dm_memWrite  (dm_memWrite),
        .dm_lwhb      (dm_lwhb),
        .dm_swhb      (dm_swhb),
        .dm_addr      (dm_addr),
        .dm_wd        (dm_wd),
        .dm_dt        (dm_dt)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    // Memory model: writes on the clock edge, reads combinationally zero-extended.
    always @(posedge clk) begin
        if (dm_memWrite) begin
            writeCount++;
            case (dm_swhb)
                SL_B: mem[dm_addr] <= dm_wd[7:0];
                SL_H: begin
                    mem[dm_addr]      <= dm_wd[7:0];
                    mem[dm_addr + 8'd1] <= dm_wd[15:8];
                end
                SL_W: begin
                    mem[dm_addr]        <= dm_wd[7:0];
                    mem[dm_addr + 8'd1] <= dm_wd[15:8];
                    mem[dm_addr + 8'd2] <= dm_wd[23:16];
                    mem[dm_addr + 8'd3] <= dm_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dm_dt = 32'd0;
        case (dm_lwhb)
            SL_B: dm_dt = {24'd0, mem[dm_addr]};
            SL_H: dm_dt = {16'd0, mem[dm_addr + 8'd1], mem[dm_addr]};
            SL_W: dm_dt = {mem[dm_addr + 8'd3], mem[dm_addr + 8'd2],
                           mem[dm_addr + 8'd1], mem[dm_addr]};
            default: dm_dt = 32'd0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction: accept, optional ACCESS checks, latency, response, stall, handshake.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input int holdCycles);
        int wcBefore;
        int lat;
        wcBefore = writeCount;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        checkOutput({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hA5A5A5A5;
        req_addr  = 8'hFF;
        if (!expErr) begin
            checkOutput({tag, "/dm_addr"}, 32'(dm_addr), 32'(addr));
            checkOutput({tag, "/dm_memWrite"}, 32'(dm_memWrite), 32'(we));
            if (we) begin
                checkOutput({tag, "/dm_swhb"}, 32'(dm_swhb), 32'(size));
                checkOutput({tag, "/dm_wd"}, dm_wd, wdata);
            end else begin
                checkOutput({tag, "/dm_lwhb"}, 32'(dm_lwhb), 32'(size));
            end
        end else begin
            checkOutput({tag, "/dm_memWrite"}, 32'(dm_memWrite), 32'd0);
        end
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        checkOutput({tag, "/latency"}, 32'(lat), expErr ? 32'd1 : 32'd2);
        checkOutput({tag, "/rdata"}, rsp_rdata, expData);
        checkOutput({tag, "/err"}, 32'(rsp_err), 32'(expErr));
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, "/hold_rdata"}, rsp_rdata, expData);
            checkOutput({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput({tag, "/post_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "/post_req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "/writes"}, 32'(writeCount - wcBefore), (we && !expErr) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int wc;
        $display("[TB] lsu_ctrl directed test");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset/req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset/rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset/rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset/dm_memWrite", 32'(dm_memWrite), 32'd0);
        checkOutput("reset/dm_addr", 32'(dm_addr), 32'd0);

        applyStimulus("stW10",   1, SL_W, 0, 8'h10, 32'hDEADBEEF, 32'h00000000, 0, 0);
        applyStimulus("ldW10",   0, SL_W, 0, 8'h10, 32'h0,        32'hDEADBEEF, 0, 0);
        applyStimulus("ldBs10",  0, SL_B, 0, 8'h10, 32'h0,        32'hFFFFFFEF, 0, 0);
        applyStimulus("ldBu10",  0, SL_B, 1, 8'h10, 32'h0,        32'h000000EF, 0, 0);
        applyStimulus("ldHs12",  0, SL_H, 0, 8'h12, 32'h0,        32'hFFFFDEAD, 0, 0);
        applyStimulus("ldHu12",  0, SL_H, 1, 8'h12, 32'h0,        32'h0000DEAD, 0, 0);
        applyStimulus("stW11",   1, SL_W, 0, 8'h11, 32'h11223344, 32'h00000000, 1, 0);
        applyStimulus("ldH13",   0, SL_H, 0, 8'h13, 32'h0,        32'h00000000, 1, 0);
        applyStimulus("ldW254",  0, SL_W, 0, 8'hFE, 32'h0,        32'h00000000, 1, 0);
        applyStimulus("ldNone",  0, SL_NONE, 0, 8'h00, 32'h0,     32'h00000000, 1, 0);
        applyStimulus("stB255",  1, SL_B, 0, 8'hFF, 32'hFFFFFF5A, 32'h00000000, 0, 0);
        applyStimulus("ldBu255", 0, SL_B, 1, 8'hFF, 32'h0,        32'h0000005A, 0, 0);
        applyStimulus("stH20",   1, SL_H, 0, 8'h20, 32'h12348001, 32'h00000000, 0, 0);
        applyStimulus("ldHs20",  0, SL_H, 0, 8'h20, 32'h0,        32'hFFFF8001, 0, 0);
        applyStimulus("ldW20",   0, SL_W, 0, 8'h20, 32'h0,        32'h00008001, 0, 0);
        applyStimulus("stall",   0, SL_W, 0, 8'h10, 32'h0,        32'hDEADBEEF, 0, 5);
        applyStimulus("b2b",     0, SL_B, 0, 8'h13, 32'h0,        32'hFFFFFFDE, 0, 0);

        // Reset lands on the edge that ends a store's ACCESS cycle.
        wc = writeCount;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SL_W;
        req_addr  = 8'h40;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rstAcc/dm_memWrite", 32'(dm_memWrite), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstAcc/rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rstAcc/req_ready", 32'(req_ready), 32'd1);
        checkOutput("rstAcc/writes", 32'(writeCount - wc), 32'd1);
        checkOutput("rstAcc/rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        checkOutput("rstAcc/rsp_valid2", 32'(rsp_valid), 32'd0);
        applyStimulus("ldW40", 0, SL_W, 0, 8'h40, 32'h0, 32'h12345678, 0, 0);

        // Reset while a response is pending drops it.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SL_W;
        req_addr  = 8'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstResp/pending", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstResp/rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rstResp/rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rstResp/req_ready", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
